bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_scan_if.sv | 30 +++
 rtl/bcd_seg_scan.sv | 196 +++++++++++++++++++
 tb/tb_bcd_seg_scan.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan_if
// Description : Valid/ready channel that carries a packed two-digit BCD value
//               into bcd_seg_scan.
// Ports       : bcd_in    [7:0]  packed BCD, [7:4] tens, [3:0] units
//               bcd_valid        producer offers bcd_in this cycle
//               bcd_ready        consumer can accept bcd_in this cycle
// Modports    : master - producer side (drives bcd_in / bcd_valid)
//               slave  - consumer side (drives bcd_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_seg_scan_if;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (
    output bcd_in,
    output bcd_valid,
    input  bcd_ready
  );

  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output bcd_ready
  );
endinterface
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : Two-digit multiplexed 7-segment driver for a packed BCD value.
//               Scans units (DIG0) and tens (DIG1) with all-off dead time
//               (GAP0/GAP1) between them. A new value is taken through a
//               valid/ready channel into a one-entry pending register and is
//               promoted to the display register only at a frame boundary,
//               so a lit digit never changes mid-period.
// Parameters  : SCAN_DIV - clk cycles each digit is lit (>= 2)
//               GAP_CYC  - clk cycles of dead time between digits (>= 1)
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of bcd_seg_scan_if (bcd_in/valid/ready)
//               lzb    - leading-zero blanking of the tens digit (live)
//               blank  - force the display dark (live)
//               an     - active-low digit enables, [0] units, [1] tens
//               seg    - active-low segments {g,f,e,d,c,b,a}
//               dp     - active-low decimal point, always off
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  bcd_seg_scan_if.slave      bus,
  input  wire logic          lzb,
  input  wire logic          blank,
  output logic [1:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  // --------------------------------------------------------------------------
  // Counter sizing: one down-counter times every state, so it must hold the
  // larger of the two reload values.
  // --------------------------------------------------------------------------
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIG_RELOAD = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYC - 1);

  // Scan states, visited strictly in this order and wrapping.
  localparam logic [1:0] ST_DIG0 = 2'd0;
  localparam logic [1:0] ST_GAP0 = 2'd1;
  localparam logic [1:0] ST_DIG1 = 2'd2;
  localparam logic [1:0] ST_GAP1 = 2'd3;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // --------------------------------------------------------------------------
  // BCD to active-low 7-segment decode; non-decimal codes show a dash.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] s;
    s = 7'h3F;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State, timer and data registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       pend_q,      pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       disp_q,      disp_d;
  logic [1:0]       an_q,        an_d;
  logic [6:0]       seg_q,       seg_d;

  logic             last_cyc;     // final cycle of the current state
  logic             enter_dig0;   // this edge is a frame boundary
  logic             accept;       // handshake completes on this edge

  // --------------------------------------------------------------------------
  // Process 1: state register (and all other flops)
  // Reset parks the scanner at the start of GAP1 so the first lit digit
  // appears exactly GAP_CYC cycles after release, with nothing partial shown.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GAP1;
      cnt_q       <= GAP_RELOAD;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      disp_q      <= 8'h00;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state, timer and data path
  // --------------------------------------------------------------------------
  always_comb begin
    last_cyc   = (cnt_q == '0);
    state_d    = state_q;
    cnt_d      = cnt_q - 1'b1;

    if (last_cyc) begin
      case (state_q)
        ST_DIG0: state_d = ST_GAP0;
        ST_GAP0: state_d = ST_DIG1;
        ST_DIG1: state_d = ST_GAP1;
        default: state_d = ST_DIG0;
      endcase
      cnt_d = ((state_d == ST_DIG0) || (state_d == ST_DIG1)) ? DIG_RELOAD
                                                            : GAP_RELOAD;
    end

    enter_dig0 = last_cyc && (state_q == ST_GAP1);

    // bcd_ready is the inverse of a flop, so accept never depends on itself.
    accept      = bus.bcd_valid && !pend_full_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;

    // A boundary copy and an accept are mutually exclusive: the copy needs
    // pend_full_q=1, which holds bcd_ready low for that same edge.
    if (enter_dig0 && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = bus.bcd_in;
      pend_full_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Process 3: output decode
  // an/seg are only recomputed on the edge that enters a state, so lzb and
  // blank are effectively sampled at state entry and held for the period.
  // disp_d is used so DIG0 shows a value promoted on that very edge.
  // --------------------------------------------------------------------------
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (last_cyc) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      if (!blank) begin
        case (state_d)
          ST_DIG0: begin
            an_d  = AN_UNITS;
            seg_d = decode(disp_d[3:0]);
          end
          ST_DIG1: begin
            if (!(lzb && (disp_d[7:4] == 4'd0))) begin
              an_d  = AN_TENS;
              seg_d = decode(disp_d[7:4]);
            end
          end
          default: begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
          end
        endcase
      end
    end
  end

  assign bus.bcd_ready = !pend_full_q;
  assign an            = an_q;
  assign seg           = seg_q;
  assign dp            = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Directed self-checking bench for bcd_seg_scan with
//               SCAN_DIV=4, GAP_CYC=2 (12-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

  localparam int SD    = 4;
  localparam int GC    = 2;
  localparam int FRAME = 2 * (SD + GC);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       lzb   = 1'b0;
  logic       blank = 1'b0;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total  = 0;
  int cyc;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(
    .SCAN_DIV (SD),
    .GAP_CYC  (GC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .lzb   (lzb),
    .blank (blank),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; edge 2 is the first DIG0 entry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Phase of the state entered most recently: 0..3 DIG0, 4..5 GAP0,
  // 6..9 DIG1, 10..11 GAP1.
  function automatic int phase();
    return (cyc >= 2) ? ((cyc - 2) % FRAME) : -1;
  endfunction

  task automatic goto_phase(input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2 && !found; i++) begin
      @(negedge clk);
      if (phase() == p) found = 1'b1;
    end
    if (!found) begin
      total++;
      $display("FAIL goto_phase: phase %0d never reached (now %0d)", p, phase());
    end
  endtask

  // Offer a value during DIG0 and wait for the frame boundary that shows it.
  task automatic load_value(input logic [7:0] v);
    goto_phase(1);
    bus.bcd_valid = 1'b1;
    bus.bcd_in    = v;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
    goto_phase(0);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.bcd_valid = 1'b1;
    bus.bcd_in    = 8'h99;
    repeat (3) @(negedge clk);
    total++; if (an !== 2'b11) $display("FAIL reset_an: got %b want 11", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else passed++;
    total++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else passed++;
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.bcd_ready); else passed++;
    rst_n         = 1'b1;
    bus.bcd_valid = 1'b0;
    @(negedge clk);
    total++; if (an !== 2'b11) $display("FAIL release_gap_an: got %b want 11", an); else passed++;
    @(negedge clk);
    total++; if (an !== 2'b10) $display("FAIL first_dig0_an: got %b want 10", an); else passed++;
    // 8'h99 offered in reset must not have been captured: units still 0
    total++; if (seg !== 7'h40) $display("FAIL first_dig0_seg: got %h want 40", seg); else passed++;
  endtask

  task automatic test_idle_scan();
    logic [1:0] ea;
    logic [6:0] es;
    int ph;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      ph = phase();
      if (ph < 4)       begin ea = 2'b10; es = 7'h40; end
      else if (ph < 6)  begin ea = 2'b11; es = 7'h7F; end
      else if (ph < 10) begin ea = 2'b01; es = 7'h40; end
      else              begin ea = 2'b11; es = 7'h7F; end
      total++; if (an !== ea) $display("FAIL idle_an ph%0d: got %b want %b", ph, an, ea); else passed++;
      total++; if (seg !== es) $display("FAIL idle_seg ph%0d: got %h want %h", ph, seg, es); else passed++;
    end
  endtask

  task automatic test_accept();
    goto_phase(7);
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL acc_ready_before: got %b want 1", bus.bcd_ready); else passed++;
    bus.bcd_valid = 1'b1;
    bus.bcd_in    = 8'h63;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL acc_ready_after: got %b want 0", bus.bcd_ready); else passed++;
    // still the old value on the tens digit
    total++; if (seg !== 7'h40) $display("FAIL acc_no_midchange: got %h want 40", seg); else passed++;
    goto_phase(11);
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL acc_ready_gap1: got %b want 0", bus.bcd_ready); else passed++;
    @(negedge clk);
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL acc_ready_dig0: got %b want 1", bus.bcd_ready); else passed++;
    total++; if (an !== 2'b10) $display("FAIL acc_units_an: got %b want 10", an); else passed++;
    total++; if (seg !== 7'h30) $display("FAIL acc_units_seg: got %h want 30", seg); else passed++;
    goto_phase(6);
    total++; if (an !== 2'b01) $display("FAIL acc_tens_an: got %b want 01", an); else passed++;
    total++; if (seg !== 7'h02) $display("FAIL acc_tens_seg: got %h want 02", seg); else passed++;
  endtask

  task automatic test_back_to_back();
    goto_phase(1);
    bus.bcd_valid = 1'b1;
    bus.bcd_in    = 8'h12;
    @(negedge clk);
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL b2b_ready_12: got %b want 0", bus.bcd_ready); else passed++;
    bus.bcd_in = 8'h34;
    goto_phase(11);
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL b2b_ready_hold: got %b want 0", bus.bcd_ready); else passed++;
    @(negedge clk);
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL b2b_ready_rise: got %b want 1", bus.bcd_ready); else passed++;
    total++; if (seg !== 7'h24) $display("FAIL b2b_units_12: got %h want 24", seg); else passed++;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL b2b_ready_34: got %b want 0", bus.bcd_ready); else passed++;
    total++; if (seg !== 7'h24) $display("FAIL b2b_units_stable: got %h want 24", seg); else passed++;
    goto_phase(6);
    total++; if (seg !== 7'h79) $display("FAIL b2b_tens_12: got %h want 79", seg); else passed++;
    goto_phase(0);
    total++; if (seg !== 7'h19) $display("FAIL b2b_units_34: got %h want 19", seg); else passed++;
    goto_phase(6);
    total++; if (seg !== 7'h30) $display("FAIL b2b_tens_34: got %h want 30", seg); else passed++;
  endtask

  task automatic test_lzb();
    load_value(8'h07);
    total++; if (seg !== 7'h78) $display("FAIL lzb_units_7: got %h want 78", seg); else passed++;
    lzb = 1'b1;
    goto_phase(6);
    total++; if (an !== 2'b11) $display("FAIL lzb_tens_an: got %b want 11", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL lzb_tens_seg: got %h want 7f", seg); else passed++;
    goto_phase(0);
    total++; if (an !== 2'b10) $display("FAIL lzb_units_an: got %b want 10", an); else passed++;
    total++; if (seg !== 7'h78) $display("FAIL lzb_units_seg: got %h want 78", seg); else passed++;
    lzb = 1'b0;
    goto_phase(6);
    total++; if (an !== 2'b01) $display("FAIL nolzb_tens_an: got %b want 01", an); else passed++;
    total++; if (seg !== 7'h40) $display("FAIL nolzb_tens_seg: got %h want 40", seg); else passed++;
  endtask

  task automatic test_blank();
    int ph;
    load_value(8'hA5);
    total++; if (seg !== 7'h12) $display("FAIL a5_units: got %h want 12", seg); else passed++;
    goto_phase(6);
    total++; if (seg !== 7'h3F) $display("FAIL a5_tens_dash: got %h want 3f", seg); else passed++;
    goto_phase(11);
    blank = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      ph = phase();
      total++; if (an !== 2'b11) $display("FAIL blank_an ph%0d: got %b want 11", ph, an); else passed++;
      total++; if (seg !== 7'h7F) $display("FAIL blank_seg ph%0d: got %h want 7f", ph, seg); else passed++;
    end
    blank = 1'b0;
    @(negedge clk);
    total++; if (an !== 2'b10) $display("FAIL unblank_an: got %b want 10", an); else passed++;
    total++; if (seg !== 7'h12) $display("FAIL unblank_seg: got %h want 12", seg); else passed++;
    goto_phase(3);
    total++; if (an !== 2'b10) $display("FAIL unblank_dig0_end: got %b want 10", an); else passed++;
    @(negedge clk);
    total++; if (an !== 2'b11) $display("FAIL unblank_gap0: got %b want 11", an); else passed++;
    goto_phase(6);
    total++; if (an !== 2'b01) $display("FAIL unblank_dig1: got %b want 01", an); else passed++;
  endtask

  task automatic test_reset_mid();
    goto_phase(0);
    bus.bcd_valid = 1'b1;
    bus.bcd_in    = 8'h45;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
    total++; if (bus.bcd_ready !== 1'b0) $display("FAIL rmid_pending: got %b want 0", bus.bcd_ready); else passed++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (an !== 2'b11) $display("FAIL rmid_an: got %b want 11", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL rmid_seg: got %h want 7f", seg); else passed++;
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", bus.bcd_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (an !== 2'b11) $display("FAIL rmid_gap_an: got %b want 11", an); else passed++;
    @(negedge clk);
    total++; if (an !== 2'b10) $display("FAIL rmid_units_an: got %b want 10", an); else passed++;
    total++; if (seg !== 7'h40) $display("FAIL rmid_units_seg: got %h want 40", seg); else passed++;
    total++; if (bus.bcd_ready !== 1'b1) $display("FAIL rmid_ready_after: got %b want 1", bus.bcd_ready); else passed++;
    goto_phase(6);
    total++; if (an !== 2'b01) $display("FAIL rmid_tens_an: got %b want 01", an); else passed++;
    total++; if (seg !== 7'h40) $display("FAIL rmid_tens_seg: got %h want 40", seg); else passed++;
  endtask

  initial begin
    bus.bcd_valid = 1'b0;
    bus.bcd_in    = 8'h00;
    test_reset();
    test_idle_scan();
    test_accept();
    test_back_to_back();
    test_lzb();
    test_blank();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
